// File: rtl/prm_edge_pkg.sv
// Shared types and sizing for the PRM edge scan collector.
// Defaults, sweep state encoding and word-index width derivation.
package prm_edge_pkg;

    localparam int PRM_CODE_W = 15;
    localparam int PRM_WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } scan_state_t;

    // Enough bits to number every word of a full 2^code_w sweep.
    function automatic int prm_idx_w(input int code_w, input int word_w);
        return code_w + 1 - $clog2(word_w);
    endfunction

endpackage

// File: rtl/prm_edge_scan_collector.sv
// Sweeps edge codes across an external obstacle checker and packs
// the per-code results into occupancy words on a valid/ready stream.
module prm_edge_scan_collector
    import prm_edge_pkg::*;
#(
    parameter int CODE_W = PRM_CODE_W,
    parameter int WORD_W = PRM_WORD_W,
    localparam int IDX_W = prm_idx_w(CODE_W, WORD_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CODE_W-1:0] base_code,
    input  logic [CODE_W:0]   count,
    input  logic              abort,
    output logic [CODE_W-1:0] chk_code,
    input  logic              chk_mask,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_word,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int FILL_W = $clog2(WORD_W);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WORD_W - 1);
    localparam logic [CODE_W:0] REM_ONE = {{CODE_W{1'b0}}, 1'b1};
    localparam logic [CODE_W:0] REM_ZERO = '0;

    scan_state_t state_q;
    scan_state_t state_d;

    logic [CODE_W:0]   remaining;
    logic [FILL_W-1:0] fill;
    logic [WORD_W-1:0] acc;
    logic [WORD_W-1:0] acc_next;
    logic [IDX_W-1:0]  word_idx;

    logic launch;
    logic kill;
    logic issue;
    logic complete;
    logic last_issue;
    logic xfer;
    logic done_d;

    assign busy = (state_q != IDLE);

    // Sweep state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle control: launch, issue, stall, finish, kill.
    always_comb begin
        state_d    = state_q;
        launch     = 1'b0;
        kill       = 1'b0;
        issue      = 1'b0;
        complete   = 1'b0;
        last_issue = 1'b0;
        done_d     = 1'b0;
        xfer       = out_valid && out_ready;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (count != REM_ZERO) begin
                        launch  = 1'b1;
                        state_d = SCAN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (abort) begin
                    kill    = 1'b1;
                    state_d = IDLE;
                end else begin
                    last_issue = (remaining == REM_ONE);
                    complete   = (fill == FILL_LAST) || last_issue;
                    // A completing issue waits for the output slot to free up.
                    issue = !(complete && out_valid && !out_ready);
                    if (issue && last_issue) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    kill    = 1'b1;
                    state_d = IDLE;
                end else if (xfer) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Accumulator with this cycle's checker result merged in.
    always_comb begin
        acc_next       = acc;
        acc_next[fill] = chk_mask;
    end

    // Datapath: code counter, packing accumulator and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_code  <= '0;
            remaining <= '0;
            fill      <= '0;
            acc       <= '0;
            word_idx  <= '0;
            out_valid <= 1'b0;
            out_word  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= done_d;
            if (launch) begin
                chk_code  <= base_code;
                remaining <= count;
                fill      <= '0;
                acc       <= '0;
                word_idx  <= '0;
            end else if (kill) begin
                out_valid <= 1'b0;
            end else begin
                if (xfer) begin
                    out_valid <= 1'b0;
                end
                if (issue) begin
                    chk_code  <= chk_code + 1'b1;
                    remaining <= remaining - 1'b1;
                    if (complete) begin
                        out_word  <= acc_next;
                        out_idx   <= word_idx;
                        out_last  <= last_issue;
                        out_valid <= 1'b1;
                        word_idx  <= word_idx + 1'b1;
                        acc       <= '0;
                        fill      <= '0;
                    end else begin
                        acc  <= acc_next;
                        fill <= fill + 1'b1;
                    end
                end
            end
        end
    end

endmodule
